free_list_ckpt: RTL and testbench
=================================

# free_list_ckpt

Parametrised superscalar physical-register free list with branch checkpoints, sitting between rename/dispatch (allocation) and the retirement RRF (release). It keeps unassigned physical register tags in a circular queue. It grants up to SS allocations and accepts up to SS releases per cycle. It snapshots the allocation pointer per in-flight branch, so a mispredict restores only the younger allocations; a full flush returns every speculative allocation.

## Interface
- SS, 2: max allocations and max releases per cycle.
- WIDTH, NUM_PHYS_REGS_BITS: physical register tag width.
- NUM_PHYS, NUM_PHYS_REGS: total physical registers.
- NUM_ARCH, 32: architectural registers. D = NUM_PHYS - NUM_ARCH must be a power of two and at least 2*SS.
- NUM_CKPT, 4: number of checkpoint slots. CB = $clog2(NUM_CKPT).
- DB: derived, $clog2(D). Pointers are DB+1 bits, with the MSB as a wrap bit.

Ports:
- clk  in  1  clock. One clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- pop_cnt  in  $clog2(SS)+1  number of tags dispatch wants this cycle.
- pop_ok  out  1  pop_cnt <= num_free; combinational.
- alloc_reg[SS]  out  WIDTH  queue[head+i]; combinational. Only the first pop_cnt entries are meaningful.
- push_cnt  in  $clog2(SS)+1  number of tags released by the RRF.
- push_reg[SS]  in  WIDTH  tags released; entries 0..push_cnt-1 are valid.
- ckpt_save  in  1  take a checkpoint into slot ckpt_id.
- ckpt_id  in  CB  slot to write.
- restore  in  1  branch mispredict; roll back to slot restore_id.
- restore_id  in  CB  slot to restore.
- flush  in  1  full pipeline flush; all speculative tags return.
- num_free  out  DB+1  registered count of free tags.

## Operation
- Storage: queue[D] of WIDTH bits, head and tail pointers, ckpt_head[NUM_CKPT], and a num_free register.
- Pop rule: head advances by pop_cnt only when pop_cnt > 0 and pop_ok = 1. When pop_ok = 0, nothing is consumed and dispatch stalls. There are no partial grants.
- Push rule: write queue[tail[DB-1:0] + i] = push_reg[i] for i < push_cnt. Then tail_next = tail + push_cnt.
- Pushes are always performed, including in flush and restore cycles, because released tags belong to committed instructions.
- Push overflow (push_cnt > D - num_free) is illegal. Verification flags it with an assertion; the RTL behaviour is undefined.
- Priority, highest first: rst, flush, restore, normal.
- flush:
  - tail <= tail_next.
  - head <= {~tail_next[DB], tail_next[DB-1:0]}.
  - num_free <= D.
  - pop, ckpt_save and restore are ignored.
- restore:
  - head <= ckpt_head[restore_id].
  - tail <= tail_next.
  - num_free <= tail_next - ckpt_head[restore_id], computed as a DB+1-bit wrap subtract.
  - pop and ckpt_save are ignored.
- Normal cycle:
  - head <= head + granted pop.
  - tail <= tail_next.
  - num_free <= num_free + push_cnt - granted pop.
- ckpt_save in a normal cycle writes ckpt_head[ckpt_id] <= head after this cycle's granted pop. The branch's own allocation and older allocations in the same group therefore survive a later restore of that slot.
- Slot liveness is owned by the branch tracker; this block never clears or validates slots.
- Because tail only moves forward and never passes head, any saved pointer remains a legal restore target until its branch resolves.

## Timing
- Reset values:
  - queue[i] = NUM_ARCH + i.
  - head = 0.
  - tail = {1'b1, DB'0}.
  - num_free = D.
  - ckpt_head[*] = 0.
  - Consequently pop_ok = 1 (for pop_cnt <= SS) and alloc_reg[i] = NUM_ARCH + i.
- Allocation latency is 0 cycles: alloc_reg and pop_ok are valid in the cycle pop_cnt is presented, and the pointer moves at the edge.
- Released tags are not visible to alloc_reg until the cycle after the push; there is no same-cycle bypass.
- Empty queue (num_free = 0): pop_ok = 1 only when pop_cnt = 0.
- Pointer wrap: the index uses the low DB bits and wraps modulo D; the wrap bit toggles.
- Reset asserted mid-operation overrides everything and reinitialises all state on that edge.

## Test plan
- Reset, then pop_cnt=2 for 16 cycles → tags 32..63 returned in order; num_free reaches 0; the next pop_cnt=1 gives pop_ok=0 and head is unchanged.
- From empty, push 40,41 → num_free=2 on the next cycle; then pop 2 → alloc_reg = 40,41, and index wrap is correct (D=32, NUM_PHYS=64).
- Pop 2 (tags 32,33) with ckpt_save slot 1, then pop 4, then restore slot 1 → num_free=30 and alloc_reg[0]=34.
- Restore slot 1 with push_cnt=2 in the same cycle → num_free = 30 + 2; the pushed tags sit at the old tail.
- flush after 10 pops and 3 pushes → num_free=32 and head = {~tail[DB], tail[DB-1:0]}; a same-cycle pop and ckpt_save are ignored.
- rst asserted during a cycle with push, pop and save all active → all state equals the reset values on the next cycle.

Source files
------------

// File: rtl/free_list_ckpt.sv
// Superscalar physical-register free list: circular queue of free tags with
// per-branch head checkpoints for mispredict rollback and full-flush recovery.
module free_list_ckpt #(
  parameter  int SS       = 2,
  parameter  int NUM_PHYS = 64,
  parameter  int WIDTH    = $clog2(NUM_PHYS),
  parameter  int NUM_ARCH = 32,
  parameter  int NUM_CKPT = 4,
  localparam int D        = NUM_PHYS - NUM_ARCH,
  localparam int DB       = $clog2(D),
  localparam int CB       = $clog2(NUM_CKPT),
  localparam int CW       = $clog2(SS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CW-1:0]    pop_cnt,
  output logic             pop_ok,
  output logic [WIDTH-1:0] alloc_reg [SS],
  input  logic [CW-1:0]    push_cnt,
  input  logic [WIDTH-1:0] push_reg [SS],
  input  logic             ckpt_save,
  input  logic [CB-1:0]    ckpt_id,
  input  logic             restore,
  input  logic [CB-1:0]    restore_id,
  input  logic             flush,
  output logic [DB:0]      num_free
);

  logic [WIDTH-1:0] queue_mem [D];
  logic [DB:0]      ckpt_head [NUM_CKPT];
  logic [DB:0]      head_reg;
  logic [DB:0]      tail_reg;
  logic [DB:0]      num_free_reg;

  logic [DB:0]      pop_ext;
  logic [DB:0]      push_ext;
  logic [DB:0]      grant;
  logic [DB:0]      head_next;
  logic [DB:0]      tail_next;
  logic [DB-1:0]    rd_idx [SS];
  logic [DB-1:0]    wr_idx [SS];
  logic [SS-1:0]    wr_en;

  assign pop_ext   = {{(DB+1-CW){1'b0}}, pop_cnt};
  assign push_ext  = {{(DB+1-CW){1'b0}}, push_cnt};
  assign pop_ok    = (pop_ext <= num_free_reg);
  // No partial grants: a request that does not fit consumes nothing.
  assign grant     = pop_ok ? pop_ext : '0;
  assign head_next = head_reg + grant;
  assign tail_next = tail_reg + push_ext;
  assign num_free  = num_free_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SS; gi++) begin : g_lane
      // Index arithmetic is DB bits wide so it wraps modulo D by itself.
      assign rd_idx[gi]    = head_reg[DB-1:0] + DB'(gi);
      assign wr_idx[gi]    = tail_reg[DB-1:0] + DB'(gi);
      assign wr_en[gi]     = (push_ext > (DB+1)'(gi));
      assign alloc_reg[gi] = queue_mem[rd_idx[gi]];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg     <= '0;
      tail_reg     <= {1'b1, {DB{1'b0}}};
      num_free_reg <= (DB+1)'(D);
      for (int i = 0; i < NUM_CKPT; i++) begin
        ckpt_head[i] <= '0;
      end
      for (int i = 0; i < D; i++) begin
        queue_mem[i] <= WIDTH'(NUM_ARCH + i);
      end
    end else begin
      // Released tags belong to committed instructions, so pushes always land.
      for (int i = 0; i < SS; i++) begin
        if (wr_en[i]) begin
          queue_mem[wr_idx[i]] <= push_reg[i];
        end
      end
      tail_reg <= tail_next;
      if (flush) begin
        head_reg     <= {~tail_next[DB], tail_next[DB-1:0]};
        num_free_reg <= (DB+1)'(D);
      end else if (restore) begin
        head_reg     <= ckpt_head[restore_id];
        num_free_reg <= tail_next - ckpt_head[restore_id];
      end else begin
        head_reg     <= head_next;
        num_free_reg <= num_free_reg + push_ext - grant;
        // Snapshot after this cycle's grant so the branch's own tags survive.
        if (ckpt_save) begin
          ckpt_head[ckpt_id] <= head_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_free_list_ckpt.sv
// Self-checking bench for free_list_ckpt: directed scenarios followed by random
// traffic, compared against a tag-list reference model.
module tb_free_list_ckpt;

  localparam int SS       = 2;
  localparam int NUM_PHYS = 64;
  localparam int NUM_ARCH = 32;
  localparam int NUM_CKPT = 4;
  localparam int D        = NUM_PHYS - NUM_ARCH;
  localparam int W        = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   pop_cnt;
  logic         pop_ok;
  logic [W-1:0] alloc_reg [SS];
  logic [1:0]   push_cnt;
  logic [W-1:0] push_reg [SS];
  logic         ckpt_save;
  logic [1:0]   ckpt_id;
  logic         restore;
  logic [1:0]   restore_id;
  logic         flush;
  logic [5:0]   num_free;

  always #5 clk = ~clk;

  free_list_ckpt #(
    .SS(SS), .NUM_PHYS(NUM_PHYS), .WIDTH(W), .NUM_ARCH(NUM_ARCH), .NUM_CKPT(NUM_CKPT)
  ) dut (
    .clk(clk), .rst(rst),
    .pop_cnt(pop_cnt), .pop_ok(pop_ok), .alloc_reg(alloc_reg),
    .push_cnt(push_cnt), .push_reg(push_reg),
    .ckpt_save(ckpt_save), .ckpt_id(ckpt_id),
    .restore(restore), .restore_id(restore_id),
    .flush(flush), .num_free(num_free)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: free tags in allocation order, and the allocated-but-not-
  // recycled tags oldest first. seq counts allocations to place checkpoints.
  int free_q[$];
  int alloc_q[$];
  int seq;
  int ck_seq [NUM_CKPT];
  bit ck_valid [NUM_CKPT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    rst        = 1'b0;
    pop_cnt    = '0;
    push_cnt   = '0;
    push_reg   = '{default: '0};
    ckpt_save  = 1'b0;
    ckpt_id    = '0;
    restore    = 1'b0;
    restore_id = '0;
    flush      = 1'b0;
  endtask

  task automatic check_outputs();
    chk("num_free", num_free, free_q.size());
    chk("pop_ok", pop_ok, (int'(pop_cnt) <= free_q.size()));
    for (int i = 0; i < SS; i++) begin
      if (i < int'(pop_cnt) && i < free_q.size())
        chk($sformatf("alloc_reg[%0d]", i), alloc_reg[i], free_q[i]);
    end
    if (!rst) begin
      n_checks++;
      assert (int'(push_cnt) <= D - free_q.size()) else begin
        n_fail++;
        $error("FAIL push_overflow: observed push_cnt %0d expected at most %0d", push_cnt, D - free_q.size());
      end
    end
  endtask

  task automatic model_step();
    int g;
    int n;
    if (rst) begin
      free_q.delete();
      alloc_q.delete();
      for (int i = 0; i < D; i++) free_q.push_back(NUM_ARCH + i);
      seq = 0;
      for (int c = 0; c < NUM_CKPT; c++) begin
        ck_seq[c]   = 0;
        ck_valid[c] = 1'b1;
      end
      return;
    end
    g = (!flush && !restore && int'(pop_cnt) <= free_q.size()) ? int'(pop_cnt) : 0;
    for (int i = 0; i < g; i++) alloc_q.push_back(free_q.pop_front());
    if (!flush && restore) begin
      n = seq - ck_seq[restore_id];
      for (int i = 0; i < n; i++) free_q.push_front(alloc_q.pop_back());
      seq = ck_seq[restore_id];
      for (int c = 0; c < NUM_CKPT; c++) if (ck_seq[c] > seq) ck_valid[c] = 1'b0;
    end
    // A release recycles the slot of the oldest allocation.
    for (int i = 0; i < int'(push_cnt); i++) begin
      void'(alloc_q.pop_front());
      free_q.push_back(int'(push_reg[i]));
    end
    if (flush) begin
      for (int i = alloc_q.size() - 1; i >= 0; i--) free_q.push_front(alloc_q[i]);
      alloc_q.delete();
      for (int c = 0; c < NUM_CKPT; c++) ck_valid[c] = 1'b0;
    end else if (!restore) begin
      if (ckpt_save) begin
        ck_seq[ckpt_id]   = seq + g;
        ck_valid[ckpt_id] = 1'b1;
      end
      seq += g;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic commit();
    @(posedge clk);
    model_step();
    #1;
    set_idle();
  endtask

  task automatic cycle();
    sample();
    commit();
  endtask

  initial begin
    int r, pc, rid;
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_step();
    #1;
    set_idle();

    // Reset state, then drain the queue two tags at a time.
    pop_cnt = 2'd2;
    sample();
    chk("reset num_free", num_free, 32);
    chk("reset alloc0", alloc_reg[0], 32);
    chk("reset alloc1", alloc_reg[1], 33);
    chk("reset pop_ok", pop_ok, 1);
    commit();
    for (int k = 1; k < 16; k++) begin
      pop_cnt = 2'd2;
      sample();
      chk("drain alloc0", alloc_reg[0], 32 + 2 * k);
      chk("drain alloc1", alloc_reg[1], 33 + 2 * k);
      commit();
    end
    pop_cnt = 2'd1;
    sample();
    chk("empty num_free", num_free, 0);
    chk("empty pop_ok", pop_ok, 0);
    commit();

    // Refill from empty across the wrap point, then reallocate.
    push_cnt = 2'd2; push_reg[0] = 6'd40; push_reg[1] = 6'd41;
    cycle();
    pop_cnt = 2'd2;
    sample();
    chk("refill num_free", num_free, 2);
    chk("refill alloc0", alloc_reg[0], 40);
    chk("refill alloc1", alloc_reg[1], 41);
    commit();

    // Checkpoint then mispredict.
    rst = 1'b1; cycle();
    pop_cnt = 2'd2; ckpt_save = 1'b1; ckpt_id = 2'd1; cycle();
    pop_cnt = 2'd2; cycle();
    pop_cnt = 2'd2; cycle();
    restore = 1'b1; restore_id = 2'd1; cycle();
    sample();
    chk("restore num_free", num_free, 30);
    chk("restore alloc0", alloc_reg[0], 34);
    commit();

    // Restore coinciding with a release.
    pop_cnt = 2'd2; cycle();
    pop_cnt = 2'd2; cycle();
    restore = 1'b1; restore_id = 2'd1;
    push_cnt = 2'd2; push_reg[0] = 6'd50; push_reg[1] = 6'd51;
    cycle();
    sample();
    chk("restore+push num_free", num_free, 32);
    commit();
    for (int k = 0; k < 16; k++) begin
      pop_cnt = 2'd2; cycle();
    end

    // Flush after 10 pops and 3 pushes; same-cycle pop and save are ignored.
    rst = 1'b1; cycle();
    for (int k = 0; k < 5; k++) begin
      pop_cnt = 2'd2; cycle();
    end
    push_cnt = 2'd2; push_reg[0] = 6'd7; push_reg[1] = 6'd8; cycle();
    push_cnt = 2'd1; push_reg[0] = 6'd9; cycle();
    flush = 1'b1; pop_cnt = 2'd2; ckpt_save = 1'b1; ckpt_id = 2'd0; cycle();
    sample();
    chk("flush num_free", num_free, 32);
    chk("flush alloc0", alloc_reg[0], 35);
    commit();
    for (int k = 0; k < 16; k++) begin
      pop_cnt = 2'd2; cycle();
    end

    // Reset wins over a simultaneous push, pop and save.
    pop_cnt = 2'd2; push_cnt = 2'd2; push_reg[0] = 6'd1; push_reg[1] = 6'd2;
    ckpt_save = 1'b1; ckpt_id = 2'd2; rst = 1'b1;
    cycle();
    sample();
    chk("midrst num_free", num_free, 32);
    chk("midrst alloc0", alloc_reg[0], 32);
    chk("midrst alloc1", alloc_reg[1], 33);
    commit();

    // Random traffic.
    for (int t = 0; t < 1500; t++) begin
      r       = $urandom_range(0, 99);
      pop_cnt = 2'($urandom_range(0, 2));
      pc      = $urandom_range(0, 2);
      if (pc > alloc_q.size()) pc = alloc_q.size();
      push_cnt    = 2'(pc);
      push_reg[0] = W'($urandom);
      push_reg[1] = W'($urandom);
      if (r < 2) begin
        flush = 1'b1;
      end else if (r < 14) begin
        rid = $urandom_range(0, NUM_CKPT - 1);
        if (ck_valid[rid] && (seq - ck_seq[rid]) <= (alloc_q.size() - pc)) begin
          restore    = 1'b1;
          restore_id = 2'(rid);
        end
      end
      ckpt_save = ($urandom_range(0, 3) == 0);
      ckpt_id   = 2'($urandom_range(0, NUM_CKPT - 1));
      if (t == 700) rst = 1'b1;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
